// File: rtl/axis_frame_gen.sv
// AXI4-Stream frame generator: emits runs of fixed-length frames with a counting
// payload word and frame index, optional idle gaps, and a graceful stop.
module axis_frame_gen #(
  parameter int DATA_WIDTH = 64,
  parameter int LEN_WIDTH  = 32
) (
  input  logic                    m_axis_aclk,
  input  logic                    m_axis_aresetn,
  input  logic                    start,
  input  logic                    stop,
  input  logic [LEN_WIDTH-1:0]    frame_len,
  input  logic [LEN_WIDTH-1:0]    frame_num,
  input  logic [LEN_WIDTH-1:0]    gap_len,
  input  logic [31:0]             seed,
  output logic                    m_axis_tvalid,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m_axis_tstrb,
  output logic                    m_axis_tlast,
  input  logic                    m_axis_tready,
  output logic                    busy,
  output logic                    done,
  output logic [LEN_WIDTH-1:0]    frames_sent
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEND = 2'd1;
  localparam logic [1:0] GAP  = 2'd2;
  localparam logic [1:0] FIN  = 2'd3;

  // Assert asynchronously, release two edges after m_axis_aresetn rises.
  logic [1:0] rst_sync;
  logic       rst_n;

  always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
    if (!m_axis_aresetn) rst_sync <= 2'b00;
    else                 rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  logic [1:0]           state;
  logic [LEN_WIDTH-1:0] len_m1, num_q, gap_q, beat_cnt, gap_cnt;
  logic [31:0]          word;
  logic [31:0]          idx32;
  logic                 stop_q;
  logic                 xfer, last_beat, run_end, stop_any;

  // Every output is decoded from registered state, so reset clears them all.
  assign m_axis_tvalid = (state == SEND);
  assign busy          = (state == SEND) || (state == GAP);
  assign done          = (state == FIN);
  assign m_axis_tstrb  = {(DATA_WIDTH/8){m_axis_tvalid}};
  assign xfer          = m_axis_tvalid & m_axis_tready;
  assign last_beat     = (beat_cnt == len_m1);
  assign m_axis_tlast  = m_axis_tvalid & last_beat;
  assign stop_any      = stop_q | stop;
  assign run_end       = (frames_sent == num_q - LEN_WIDTH'(1));

  generate
    if (LEN_WIDTH >= 32) begin : g_idx_trunc
      assign idx32 = frames_sent[31:0];
    end else begin : g_idx_ext
      assign idx32 = {{(32-LEN_WIDTH){1'b0}}, frames_sent};
    end
  endgenerate

  always_comb begin
    m_axis_tdata        = '0;
    m_axis_tdata[31:0]  = word;
    m_axis_tdata[63:32] = idx32;
  end

  always_ff @(posedge m_axis_aclk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      len_m1      <= '0;
      num_q       <= '0;
      gap_q       <= '0;
      beat_cnt    <= '0;
      gap_cnt     <= '0;
      word        <= '0;
      frames_sent <= '0;
      stop_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          len_m1      <= (frame_len == '0) ? '0 : frame_len - LEN_WIDTH'(1);
          num_q       <= frame_num;
          gap_q       <= gap_len;
          word        <= seed;
          frames_sent <= '0;
          beat_cnt    <= '0;
          stop_q      <= 1'b0;
          state       <= (frame_num == '0) ? FIN : SEND;
        end
        SEND: begin
          if (stop) stop_q <= 1'b1;
          if (xfer) begin
            word <= word + 32'd1;
            if (last_beat) begin
              beat_cnt    <= '0;
              frames_sent <= frames_sent + LEN_WIDTH'(1);
              if (run_end || stop_any) begin
                state <= FIN;
              end else if (gap_q != '0) begin
                state   <= GAP;
                gap_cnt <= gap_q - LEN_WIDTH'(1);
              end
            end else begin
              beat_cnt <= beat_cnt + LEN_WIDTH'(1);
            end
          end
        end
        GAP: begin
          if (stop) stop_q <= 1'b1;
          if (gap_cnt == '0) state   <= stop_any ? FIN : SEND;
          else               gap_cnt <= gap_cnt - LEN_WIDTH'(1);
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_frame_gen.sv
// Directed bench for axis_frame_gen: table of run configurations with a
// beat-level reference model, plus hand sequences for reset and latency.
module tb_axis_frame_gen;
  localparam int DW = 96;
  localparam int LW = 32;

  logic            clk = 1'b0;
  logic            aresetn;
  logic            start, stop, tready;
  logic [LW-1:0]   frame_len, frame_num, gap_len;
  logic [31:0]     seed;
  logic            tvalid, tlast, busy, done;
  logic [DW-1:0]   tdata;
  logic [DW/8-1:0] tstrb;
  logic [LW-1:0]   frames_sent;

  axis_frame_gen #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .m_axis_aclk(clk), .m_axis_aresetn(aresetn), .start(start), .stop(stop),
    .frame_len(frame_len), .frame_num(frame_num), .gap_len(gap_len), .seed(seed),
    .m_axis_tvalid(tvalid), .m_axis_tdata(tdata), .m_axis_tstrb(tstrb),
    .m_axis_tlast(tlast), .m_axis_tready(tready), .busy(busy), .done(done),
    .frames_sent(frames_sent)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] len, num, gap, seed;
    bit          bp;
    int          stop_beat;   // 1-based beat of the run on which stop is pulsed, 0 = none
    bit          stop_gap;
    int          exp_beats, exp_tlasts, exp_frames, exp_low;
    logic [31:0] exp_last;
  } vec_t;

  vec_t vecs[9];
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int id, input vec_t v);
    int k, el, r_low, r_tlasts, r_err;
    bit seen_done, stall_prev, gap_stopped, lat_ok;
    logic [DW-1:0] hold_data;
    logic hold_last;
    logic [31:0] r_last, fs_end;
    string tag;
    tag = $sformatf("v%0d", id);
    k = 0; r_low = 0; r_tlasts = 0; r_err = 0; r_last = '0;
    seen_done = 0; stall_prev = 0; gap_stopped = 0;
    hold_data = '0; hold_last = 0;
    el = (v.len == 0) ? 1 : int'(v.len);
    @(negedge clk); stop = 1;   // stop while idle must not affect the run
    @(negedge clk); stop = 0;
    frame_len = v.len; frame_num = v.num; gap_len = v.gap; seed = v.seed;
    start = 1; tready = 1;
    @(negedge clk); start = 0;
    frame_len = $urandom; frame_num = $urandom; gap_len = $urandom; seed = $urandom;
    lat_ok = (v.num != 0) ? (tvalid && busy) : (done && !tvalid);
    chk({tag, "_latency"}, 64'(lat_ok), 64'd1);
    for (int cyc = 0; cyc < 4000 && !seen_done; cyc++) begin
      if (cyc > 0) @(negedge clk);
      start = 0; stop = 0;
      if (done) begin
        seen_done = 1;
        if (busy || tvalid) r_err++;
      end else if (tvalid) begin
        if (stall_prev && (tdata !== hold_data || tlast !== hold_last)) r_err++;
        if (tstrb !== {(DW/8){1'b1}}) r_err++;
        if (tdata[DW-1:64] !== '0) r_err++;
        tready = v.bp ? 1'($urandom_range(0, 1)) : 1'b1;
        if (v.stop_beat > 0 && k == v.stop_beat - 1) stop = 1;
        if (k == 1) start = 1;
        if (tready) begin
          if (tdata[31:0] !== v.seed + 32'(k)) r_err++;
          if (tdata[63:32] !== 32'(k / el)) r_err++;
          if (tlast !== ((k % el) == el - 1)) r_err++;
          if (tlast) r_tlasts++;
          r_last = tdata[31:0];
          k++;
        end
        stall_prev = !tready; hold_data = tdata; hold_last = tlast;
      end else begin
        if (stall_prev) r_err++;
        stall_prev = 0;
        if (tstrb !== '0) r_err++;
        if (busy) begin
          r_low++;
          if (v.stop_gap && !gap_stopped) begin stop = 1; gap_stopped = 1; end
        end
      end
    end
    chk({tag, "_done_seen"}, 64'(seen_done), 64'd1);
    fs_end = frames_sent;
    chk({tag, "_frames_sent"}, 64'(fs_end), 64'(v.exp_frames));
    chk({tag, "_beats"}, 64'(k), 64'(v.exp_beats));
    chk({tag, "_tlasts"}, 64'(r_tlasts), 64'(v.exp_tlasts));
    chk({tag, "_idle_in_run"}, 64'(r_low), 64'(v.exp_low));
    chk({tag, "_beat_errors"}, 64'(r_err), 64'd0);
    if (v.exp_beats > 0) chk({tag, "_last_word"}, 64'(r_last), 64'(v.exp_last));
    stop = 0; tready = 1;
    @(negedge clk);
    chk({tag, "_done_width"}, {62'd0, done, busy}, 64'd0);
    repeat (2) @(negedge clk);
    chk({tag, "_frames_hold"}, 64'(frames_sent), 64'(v.exp_frames));
  endtask

  initial begin
    int cnt;
    //          len    num    gap   seed           bp stop gap beats tl fr low last
    vecs[0] = '{32'd4, 32'd2, 32'd0, 32'h10,       0, 0, 0,   8,   2, 2, 0, 32'h17};
    vecs[1] = '{32'd3, 32'd2, 32'd2, 32'h0,        0, 0, 0,   6,   2, 2, 2, 32'h5};
    vecs[2] = '{32'd4, 32'd1, 32'd0, 32'hFFFFFFFE, 0, 0, 0,   4,   1, 1, 0, 32'h1};
    vecs[3] = '{32'd0, 32'd3, 32'd1, 32'h100,      0, 0, 0,   3,   3, 3, 2, 32'h102};
    vecs[4] = '{32'd3, 32'd4, 32'd1, 32'h55,       1, 0, 0,  12,   4, 4, 3, 32'h60};
    vecs[5] = '{32'd4, 32'd5, 32'd0, 32'h20,       0, 2, 0,   4,   1, 1, 0, 32'h23};
    vecs[6] = '{32'd3, 32'd3, 32'd0, 32'h30,       0, 3, 0,   3,   1, 1, 0, 32'h32};
    vecs[7] = '{32'd2, 32'd4, 32'd3, 32'h40,       0, 0, 1,   2,   1, 1, 3, 32'h41};
    vecs[8] = '{32'd5, 32'd0, 32'd2, 32'h50,       0, 0, 0,   0,   0, 0, 0, 32'h0};

    aresetn = 0; start = 0; stop = 0; tready = 1;
    frame_len = '0; frame_num = '0; gap_len = '0; seed = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {61'd0, tvalid, busy, done}, 64'd0);
    aresetn = 1;
    repeat (4) @(negedge clk);
    chk("post_reset_tdata", 64'(tdata[63:0]), 64'd0);
    chk("post_reset_frames", 64'(frames_sent), 64'd0);

    for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

    // Reset in the middle of frame 0, on beat 2.
    @(negedge clk);
    frame_len = 4; frame_num = 2; gap_len = 0; seed = 32'h70; start = 1; tready = 1;
    @(negedge clk); start = 0;
    @(negedge clk);
    chk("midreset_pre_word", 64'(tdata[31:0]), 64'h71);
    #2 aresetn = 0;
    #1;
    chk("midreset_valid_last", {62'd0, tvalid, tlast}, 64'd0);
    chk("midreset_busy_done", {62'd0, busy, done}, 64'd0);
    chk("midreset_tdata", 64'(tdata[63:0]), 64'd0);
    chk("midreset_tstrb", 64'(tstrb), 64'd0);
    chk("midreset_frames", 64'(frames_sent), 64'd0);
    @(negedge clk); aresetn = 1;
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (tvalid || busy) cnt++;
    end
    chk("no_beat_after_reset", 64'(cnt), 64'd0);
    run_vec(9, vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/axis_frame_gen.md
AXIS_FRAME_GEN -- requirements
Module: axis_frame_gen

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 64, setting the tdata width in bits; legal values are multiples of 8 that are at least 64.
REQ-002 The block SHALL have parameter LEN_WIDTH, default 32, setting the width of frame_len, frame_num and gap_len.
REQ-003 Port m_axis_aclk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 Port m_axis_aresetn, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port start, input, 1 bit: one-cycle request to begin a run.
REQ-006 Port stop, input, 1 bit: graceful stop request.
REQ-007 Port frame_len, input, LEN_WIDTH bits: beats per frame.
REQ-008 Port frame_num, input, LEN_WIDTH bits: frames per run.
REQ-009 Port gap_len, input, LEN_WIDTH bits: idle cycles between frames.
REQ-010 Port seed, input, 32 bits: first payload word of the run.
REQ-011 Port m_axis_tvalid, output, 1 bit.
REQ-012 Port m_axis_tdata, output, DATA_WIDTH bits.
REQ-013 Port m_axis_tstrb, output, DATA_WIDTH/8 bits.
REQ-014 Port m_axis_tlast, output, 1 bit.
REQ-015 Port m_axis_tready, input, 1 bit.
REQ-016 Port busy, output, 1 bit: high while a run is active.
REQ-017 Port done, output, 1 bit: one-cycle pulse at the end of a run.
REQ-018 Port frames_sent, output, LEN_WIDTH bits: count of completed frames in the current or last run.

Function
REQ-019 The block SHALL implement the states IDLE, SEND, GAP and FIN.
REQ-020 In IDLE, start=1 SHALL latch frame_len, frame_num, gap_len and seed, clear frames_sent, and move to SEND; busy and m_axis_tvalid SHALL both be 1 on the next cycle (latency 1).
REQ-021 start SHALL be ignored outside IDLE, and configuration input changes SHALL be ignored outside IDLE.
REQ-022 A latched frame_len of 0 SHALL be treated as 1.
REQ-023 A latched frame_num of 0 SHALL go IDLE->FIN with no beats sent.
REQ-024 A beat SHALL transfer only on a cycle with m_axis_tvalid=1 and m_axis_tready=1.
REQ-025 While m_axis_tvalid=1 and m_axis_tready=0, m_axis_tdata and m_axis_tlast SHALL hold stable, and m_axis_tvalid SHALL NOT deassert.
REQ-026 m_axis_tdata[31:0] SHALL equal the payload word, which starts at seed and increments by 1 per transferred beat across the whole run, wrapping modulo 2^32 (0xFFFFFFFF -> 0x00000000).
REQ-027 m_axis_tdata[63:32] SHALL equal the index of the current frame in the run, starting at 0.
REQ-028 m_axis_tdata bits above 63 SHALL be 0.
REQ-029 m_axis_tstrb SHALL be all ones whenever m_axis_tvalid=1, and 0 otherwise.
REQ-030 m_axis_tlast SHALL be 1 exactly on beat frame_len of each frame.
REQ-031 On transfer of a tlast beat, frames_sent SHALL increment on the same clock edge.
REQ-032 On a tlast transfer when the run is complete (frames_sent+1 == frame_num, or stop was registered), the block SHALL go to FIN.
REQ-033 On a tlast transfer when the run is not complete and gap_len=0, the block SHALL stay in SEND with m_axis_tvalid held at 1, giving back-to-back frames.
REQ-034 On a tlast transfer when the run is not complete and gap_len>0, the block SHALL go to GAP with m_axis_tvalid=0 for exactly gap_len cycles, then return to SEND.
REQ-035 A stop pulse in SEND or GAP SHALL be registered and SHALL cut no frame short: the current frame completes, no further frame starts, and if stop arrives in GAP the block goes to FIN when the gap ends.
REQ-036 stop in IDLE SHALL have no effect.
REQ-037 stop and tlast transfer on the same cycle SHALL go to FIN.
REQ-038 FIN SHALL last one cycle: done=1 and busy=0 in that cycle, then IDLE.
REQ-039 frames_sent SHALL hold its value until the next accepted start.
REQ-040 Internal beat and frame counters SHALL be LEN_WIDTH bits wide, and frame_num = 2^LEN_WIDTH-1 SHALL complete without overflow.

Reset
REQ-041 Assertion of m_axis_aresetn=0 SHALL asynchronously force state IDLE and drive m_axis_tvalid, m_axis_tlast, m_axis_tdata, m_axis_tstrb, busy, done and frames_sent to 0, and clear the registered stop request.
REQ-042 Reset asserted mid-frame SHALL abandon the frame; after deassertion, no beat SHALL be emitted until a new start.
REQ-043 Reset deassertion SHALL be synchronised so that the first active edge is clean.

Verification
REQ-044 frame_len=4, frame_num=2, gap_len=0, seed=0x10, tready=1 -> 8 consecutive beats with words 0x10..0x17 and tlast on beats 4 and 8, then a done pulse, with frames_sent=2.
REQ-045 frame_len=3, frame_num=2, gap_len=2 -> tvalid low for exactly 2 cycles between the frames, and tdata[63:32]=0 then 1.
REQ-046 Random tready backpressure (~50%) -> tdata and tlast stable while stalled, no beat lost or duplicated, and a receiving checker reports frame length 3.
REQ-047 seed=0xFFFFFFFE, frame_len=4 -> words 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1.
REQ-048 stop asserted on beat 2 of frame 1 of 5 (frame_len=4) -> frame 1 completes with 4 beats, then done, with frames_sent=1.
REQ-049 Reset pulsed on beat 2 of a frame -> all outputs 0 immediately, and no tvalid until the next start; separately, frame_num=0 -> done one cycle after start with zero beats.
